// File: rtl/port_fifo_hub.sv
// Per-port TX/RX word-pair FIFOs between a CPU strobe interface and a device handshake.
// Each port is independent; halt flags CPU strobes that hit a full TX or empty RX.
module port_fifo_hub #(
    parameter int PORT_COUNT = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PORT_COUNT*2*DATA_WIDTH-1:0]  port_d_out,
    input  logic [PORT_COUNT-1:0]               port_inform_write,
    input  logic [PORT_COUNT-1:0]               port_inform_read,
    output logic [PORT_COUNT*2*DATA_WIDTH-1:0]  port_d_in,
    output logic                                halt,
    output logic [PORT_COUNT-1:0]               dev_tx_valid,
    output logic [PORT_COUNT*2*DATA_WIDTH-1:0]  dev_tx_data,
    input  logic [PORT_COUNT-1:0]               dev_tx_ready,
    input  logic [PORT_COUNT-1:0]               dev_rx_valid,
    input  logic [PORT_COUNT*2*DATA_WIDTH-1:0]  dev_rx_data,
    output logic [PORT_COUNT-1:0]               dev_rx_ready,
    output logic [PORT_COUNT-1:0]               err_overflow,
    output logic [PORT_COUNT-1:0]               err_underflow
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PORT_COUNT-1:0] halt_vec;

    assign halt = |halt_vec;

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        logic [PW-1:0] tx_mem [DEPTH];
        logic [PW-1:0] rx_mem [DEPTH];
        logic [AW-1:0] tx_rd;
        logic [AW-1:0] tx_wr;
        logic [AW-1:0] rx_rd;
        logic [AW-1:0] rx_wr;
        logic [CW-1:0] tx_cnt;
        logic [CW-1:0] rx_cnt;
        logic          tx_full;
        logic          tx_empty;
        logic          rx_full;
        logic          rx_empty;
        logic          tx_push;
        logic          tx_pop;
        logic          rx_push;
        logic          rx_pop;
        logic          ovf_q;
        logic          unf_q;

        assign tx_full  = (tx_cnt == FULL);
        assign tx_empty = (tx_cnt == '0);
        assign rx_full  = (rx_cnt == FULL);
        assign rx_empty = (rx_cnt == '0);

        // A push on a full TX is rejected even when the device pops that edge
        assign tx_push = port_inform_write[p] & ~tx_full;
        assign tx_pop  = dev_tx_ready[p] & ~tx_empty;
        assign rx_pop  = port_inform_read[p] & ~rx_empty;
        assign rx_push = dev_rx_valid[p] & ~rx_full;

        assign dev_tx_valid[p]          = ~rst & ~tx_empty;
        assign dev_tx_data[p*PW +: PW]  = tx_mem[tx_rd];
        assign dev_rx_ready[p]          = ~rst & ~rx_full;
        assign port_d_in[p*PW +: PW]    = (rst | rx_empty) ? '0 : rx_mem[rx_rd];
        assign err_overflow[p]          = ovf_q;
        assign err_underflow[p]         = unf_q;

        assign halt_vec[p] = ~rst & ((port_inform_write[p] & tx_full) |
                                     (port_inform_read[p] & rx_empty));

        always_ff @(posedge clk) begin
            if (!rst && tx_push) begin
                tx_mem[tx_wr] <= port_d_out[p*PW +: PW];
            end
            if (!rst && rx_push) begin
                rx_mem[rx_wr] <= dev_rx_data[p*PW +: PW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tx_rd  <= '0;
                tx_wr  <= '0;
                tx_cnt <= '0;
                rx_rd  <= '0;
                rx_wr  <= '0;
                rx_cnt <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (tx_push) begin
                    tx_wr <= tx_wr + AW'(1);
                end
                if (tx_pop) begin
                    tx_rd <= tx_rd + AW'(1);
                end
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
                if (rx_push) begin
                    rx_wr <= rx_wr + AW'(1);
                end
                if (rx_pop) begin
                    rx_rd <= rx_rd + AW'(1);
                end
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
                if (port_inform_write[p] && tx_full) begin
                    ovf_q <= 1'b1;
                end
                if (port_inform_read[p] && rx_empty) begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/port_fifo_hub.md
PORT_FIFO_HUB -- requirements
Module: port_fifo_hub

Interface
REQ-001 Parameter PORT_COUNT, default 4: number of I/O ports; each port carries a pair of words (word 0, word 1).
REQ-002 Parameter DATA_WIDTH, default 16: width of each word.
REQ-003 Parameter DEPTH, default 4: entries per FIFO, each entry one word pair; power of two, >= 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 port_d_out  in  PORT_COUNT*2*DATA_WIDTH  CPU write data; port p word w at bits [(2p+w)*DATA_WIDTH +: DATA_WIDTH].
REQ-007 port_inform_write  in  PORT_COUNT  CPU write strobe per port; one cycle per pair.
REQ-008 port_inform_read  in  PORT_COUNT  CPU read strobe per port; pops the RX head.
REQ-009 port_d_in  out  PORT_COUNT*2*DATA_WIDTH  RX FIFO head per port, same packing as port_d_out.
REQ-010 halt  out  1  stall request to the CPU.
REQ-011 dev_tx_valid  out  PORT_COUNT;  dev_tx_data  out  PORT_COUNT*2*DATA_WIDTH;  dev_tx_ready  in  PORT_COUNT: device-side TX handshake.
REQ-012 dev_rx_valid  in  PORT_COUNT;  dev_rx_data  in  PORT_COUNT*2*DATA_WIDTH;  dev_rx_ready  out  PORT_COUNT: device-side RX handshake.
REQ-013 err_overflow  out  PORT_COUNT;  err_underflow  out  PORT_COUNT: sticky error flags.

Function
REQ-014 Each port owns one TX FIFO (CPU to device) and one RX FIFO (device to CPU); ports are fully independent.
REQ-015 Each FIFO: read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; count of $clog2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.
REQ-016 TX push: port_inform_write[p]==1 with TX not full -> port_d_out pair stored at the edge.
REQ-017 TX push on full -> rejected, even if a TX pop occurs in the same cycle; err_overflow[p] set.
REQ-018 dev_tx_valid[p] = TX not empty; dev_tx_data shows the head pair; pop on the edge where valid and dev_tx_ready[p] are both 1.
REQ-019 Simultaneous TX push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
REQ-020 Push into an empty TX FIFO -> dev_tx_valid high the following cycle, never in the same cycle.
REQ-021 dev_rx_ready[p] = RX not full and rst low; push on the edge where dev_rx_valid and dev_rx_ready are both 1.
REQ-022 port_d_in[p] = RX head pair when RX not empty, else all zeros; first-word-fall-through, visible the cycle after the push edge.
REQ-023 port_inform_read[p] with RX not empty -> head popped at the edge; read on empty -> no state change, err_underflow[p] set.
REQ-024 Simultaneous RX push and pop: pop then push semantics, count unchanged; on full, dev_rx_ready stays 0, so no push occurs that cycle.
REQ-025 halt = OR over p of (port_inform_write[p] & TX full) | (port_inform_read[p] & RX empty); purely combinational, same cycle as the strobe.
REQ-026 err_overflow and err_underflow bits are sticky until rst; the strobe that sets a bit is otherwise ignored.

Reset
REQ-027 rst high at an edge -> all pointers and counts 0, err flags 0, contents discarded; applies mid-transfer as well.
REQ-028 While rst is high: dev_tx_valid 0, dev_rx_ready 0, port_d_in 0, halt 0; all strobes and handshakes ignored.
REQ-029 First cycle after rst falls: dev_rx_ready all 1, dev_tx_valid all 0.

Verification
REQ-030 Port 0 write of 0x0055/0x0066, dev_tx_ready=1 -> next cycle dev_tx_valid[0]=1, data 0x0055/0x0066; popped that edge, valid 0 afterwards.
REQ-031 Five writes to port 1 with dev_tx_ready=0, DEPTH 4 -> 5th cycle: halt=1, err_overflow[1]=1, FIFO holds the first four pairs in order.
REQ-032 Device pushes 0x1234/0xABCD to port 2 RX -> port_d_in[2] shows the pair next cycle; port_inform_read pops, port_d_in[2] returns to 0.
REQ-033 Read strobe on empty port 3 -> halt=1 that cycle, err_underflow[3]=1, no pointer change.
REQ-034 Fill RX of port 0, then rst pulse mid-stream -> all counts 0, port_d_in 0, flags clear, dev_rx_ready=1 after release.
REQ-035 Wrap: 10 push/pop pairs through one TX FIFO with DEPTH 4 -> order preserved across pointer wrap; simultaneous push+pop keeps count constant.
